plru_state_ctrl: RTL and testbench
==================================

// Module: plru_state_ctrl
// PURPOSE
//  Owns the tree-PLRU state for every set of a set-associative cache. Sequences read-modify-write of
//  that state per access: picks the victim way on a miss, commits the updated bits on hit or fill.
//  Also runs a flush sweep that clears all sets. Sits between the cache control FSM and tag/data arrays.
// PARAMETERS
//  s_way    2                      log2 of associativity
//  num_ways 2**s_way               ways per set; PLRU bits per set = num_ways-1
//  s_index  4                      log2 of set count
//  num_sets 2**s_index             sets held in the state array
// PORTS
//  clk         in   1              clock, all state on rising edge
//  rst_n       in   1              asynchronous active-low reset
//  req_valid   in   1              access request present
//  req_ready   out  1              request accepted on edge where valid&&ready
//  req_set     in   s_index        set index of access
//  req_hits    in   num_ways       one-hot hit vector; all-zero = miss
//  req_update  in   1              1 = commit new PLRU bits; 0 = peek only
//  rsp_valid   out  1              response present
//  rsp_ready   in   1              consumer takes response on edge where valid&&ready
//  rsp_way     out  num_ways       one-hot way: hit way, else PLRU victim
//  rsp_miss    out  1              1 when req_hits was all-zero
//  rsp_set     out  s_index        set index of the response
//  flush_req   in   1              level request to clear all PLRU state
//  flush_busy  out  1              high from flush acceptance until sweep completes
// BEHAVIOUR
//  - Reset (rst_n=0, async): all num_sets state entries = 0. FSM=IDLE, stage B empty.
//    Outputs: req_ready=1, rsp_valid=0, rsp_way=0, rsp_miss=0, rsp_set=0, flush_busy=0.
//  - Tree encoding: node k of level l is bit 2**l-1+k. Bit 0 walks the victim to child 2k (lower ways).
//    Bit 1 walks it to child 2k+1. Ways are the leaves, way 0 leftmost.
//  - Update rule: on commit, every node on the path to rsp_way is written.
//    Value is 1 if the path went to child 2k, 0 if it went to child 2k+1. Off-path nodes are kept.
//  - Pipeline: accept at edge N captures set, hits, update and that set's state into stage B.
//    Cycle N+1: rsp_valid=1; rsp_way/rsp_miss are combinational from stage B.
//    Latency is 1 cycle, throughput 1 per cycle.
//  - Commit: state array written at the edge where rsp_valid&&rsp_ready&&update. Peeks never write.
//  - req_ready = (FSM==IDLE) && (!rsp_valid || rsp_ready). Stalled response holds all rsp_* stable.
//  - Bypass: if an accept coincides with a commit to the same set, stage B captures the new bits.
//    It must not capture the stale array value. Back-to-back misses to one set give distinct victims.
//  - Multi-hot req_hits is illegal. An assertion fires; rsp_way = req_hits and the array is not written.
//  - FSM IDLE: flush_req=1 -> DRAIN if stage B holds an unretired response, else FLUSH.
//    flush_busy=1 from the following cycle.
//  - FSM DRAIN: req_ready=0; go to FLUSH on the edge stage B retires.
//  - FSM FLUSH: counter starts at 0 and clears one set per cycle, incrementing each cycle.
//    After clearing set num_sets-1: counter wraps to 0, FSM -> IDLE, flush_busy=0 next cycle.
//    Sweep takes num_sets cycles.
//  - flush_req held high after completion starts a new flush. flush_req outside IDLE is ignored.
//  - Accept and flush_req in the same IDLE cycle: the request is accepted.
//    Flush then proceeds through DRAIN.
//  - Async reset mid-flush or mid-stall: everything returns to reset values immediately.
//    No partial commit survives.
// TESTING
//  1) set 3 from reset, 4 back-to-back update misses, rsp_ready=1.
//     -> rsp_way 0001, 0100, 0010, 1000. State 011, 110, 101, 000.
//  2) set 5 state 000, hit way2 (hits=0100, update=1) -> rsp_way=0100, rsp_miss=0, state 100.
//  3) set 7 state 000, peek miss twice -> rsp_way=0001 both times, state stays 000.
//  4) Miss to set 2 with rsp_ready=0 for 3 cycles -> req_ready=0, rsp_* stable.
//     State 011 written only on the release edge.
//  5) Bypass: accept miss to set 1 on the same edge set 1 commits 011 -> second rsp_way=0100.
//  6) flush_req while stage B stalled -> DRAIN until retire, then 16 FLUSH cycles.
//     flush_busy high throughout, req_ready=0. Every set reads 000 afterwards.

Source files
------------

// File: rtl/plru_state_ctrl_if.sv
// Access, response and flush signals between the cache control FSM and the
// tree-PLRU state controller.
interface plru_state_ctrl_if #(
  parameter int s_way   = 2,
  parameter int s_index = 4
);
  localparam int num_ways = 2 ** s_way;

  logic                req_valid;
  logic                req_ready;
  logic [s_index-1:0]  req_set;
  logic [num_ways-1:0] req_hits;
  logic                req_update;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [num_ways-1:0] rsp_way;
  logic                rsp_miss;
  logic [s_index-1:0]  rsp_set;
  logic                flush_req;
  logic                flush_busy;

  modport master (
    output req_valid, req_set, req_hits, req_update, rsp_ready, flush_req,
    input  req_ready, rsp_valid, rsp_way, rsp_miss, rsp_set, flush_busy
  );

  modport slave (
    input  req_valid, req_set, req_hits, req_update, rsp_ready, flush_req,
    output req_ready, rsp_valid, rsp_way, rsp_miss, rsp_set, flush_busy
  );
endinterface

// File: rtl/plru_state_ctrl.sv
// Tree-PLRU state owner: one-stage read-modify-write pipeline per access,
// same-set bypass, and a drain-then-sweep flush sequencer.
module plru_state_ctrl #(
  parameter int s_way   = 2,
  parameter int s_index = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  plru_state_ctrl_if.slave bus
);
  localparam int num_ways = 2 ** s_way;
  localparam int num_sets = 2 ** s_index;
  localparam int num_bits = num_ways - 1;

  typedef logic [num_bits-1:0] plru_t;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Follow the tree from the root: a 0 bit steers to the lower child.
  function automatic logic [s_way-1:0] plru_victim(input plru_t bits);
    int unsigned k;
    plru_t       walk;
    k = 32'd0;
    for (int l = 0; l < s_way; l++) begin
      walk = bits >> ((32'd1 << l) - 32'd1 + k);
      k    = 32'd2 * k + {31'd0, walk[0]};
    end
    return s_way'(k);
  endfunction

  function automatic plru_t plru_touch(input plru_t bits, input logic [s_way-1:0] way);
    plru_t            nb;
    int unsigned      k;
    int unsigned      node;
    logic [s_way-1:0] step;
    nb = bits;
    for (int l = 0; l < s_way; l++) begin
      k    = 32'(way) >> (s_way - l);
      node = (32'd1 << l) - 32'd1 + k;
      step = way >> (s_way - 1 - l);
      if (step[0]) begin
        nb = nb & ~(plru_t'(1'b1) << node);
      end else begin
        nb = nb | (plru_t'(1'b1) << node);
      end
    end
    return nb;
  endfunction

  function automatic logic [s_way-1:0] onehot_index(input logic [num_ways-1:0] oh);
    logic [s_way-1:0]    idx;
    logic [num_ways-1:0] sh;
    idx = '0;
    for (int w = 0; w < num_ways; w++) begin
      sh  = oh >> w;
      idx = idx | (sh[0] ? s_way'(w) : s_way'(1'b0));
    end
    return idx;
  endfunction

  plru_t               plru_mem_r [num_sets];
  state_t              state_r;
  state_t              state_next_s;
  logic [s_index-1:0]  flush_cnt_r;
  logic                flush_busy_r;

  logic                b_valid_r;
  logic [s_index-1:0]  b_set_r;
  logic [num_ways-1:0] b_hits_r;
  logic                b_update_r;
  plru_t               b_bits_r;

  logic                b_miss_s;
  logic                b_multi_s;
  logic [s_way-1:0]    way_idx_s;
  logic [num_ways-1:0] way_oh_s;
  plru_t               new_bits_s;
  plru_t               fetch_bits_s;
  logic                retire_s;
  logic                commit_s;
  logic                accept_s;
  logic                bypass_s;
  logic                req_ready_s;

  // Decode the held access; a commit landing on the set being fetched is forwarded.
  always_comb begin
    b_miss_s  = (b_hits_r == '0);
    b_multi_s = ((b_hits_r & (b_hits_r - num_ways'(1'b1))) != '0);
    if (b_miss_s) begin
      way_idx_s = plru_victim(b_bits_r);
      way_oh_s  = num_ways'(1'b1) << way_idx_s;
    end else begin
      way_idx_s = onehot_index(b_hits_r);
      way_oh_s  = b_hits_r;
    end
    new_bits_s = plru_touch(b_bits_r, way_idx_s);
    retire_s   = b_valid_r && bus.rsp_ready;
    commit_s   = retire_s && b_update_r && !b_multi_s;
    accept_s   = bus.req_valid && req_ready_s;
    bypass_s   = commit_s && (b_set_r == bus.req_set);
    if (bypass_s) begin
      fetch_bits_s = new_bits_s;
    end else begin
      fetch_bits_s = plru_mem_r[bus.req_set];
    end
  end

  // Stage B holds one access from acceptance until its response retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid_r  <= 1'b0;
      b_set_r    <= '0;
      b_hits_r   <= '0;
      b_update_r <= 1'b0;
      b_bits_r   <= '0;
    end else if (accept_s) begin
      b_valid_r  <= 1'b1;
      b_set_r    <= bus.req_set;
      b_hits_r   <= bus.req_hits;
      b_update_r <= bus.req_update;
      b_bits_r   <= fetch_bits_s;
    end else if (retire_s) begin
      b_valid_r  <= 1'b0;
    end
  end

  // State array: the sweep clears one set per cycle, otherwise retired updates commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plru_mem_r <= '{default: '0};
    end else if (state_r == ST_FLUSH) begin
      plru_mem_r[flush_cnt_r] <= '0;
    end else if (commit_s) begin
      plru_mem_r[b_set_r] <= new_bits_s;
    end
  end

  // Sweep counter wraps to zero naturally after the last set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_r <= '0;
    end else if (state_r == ST_FLUSH) begin
      flush_cnt_r <= flush_cnt_r + s_index'(1'b1);
    end
  end

  // Flush sequencer state register; busy is registered off the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      flush_busy_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      flush_busy_r <= (state_next_s != ST_IDLE);
    end
  end

  // A flush must first drain any access still occupying stage B after this edge.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.flush_req) begin
          if (accept_s || (b_valid_r && !bus.rsp_ready)) begin
            state_next_s = ST_DRAIN;
          end else begin
            state_next_s = ST_FLUSH;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!b_valid_r || bus.rsp_ready) begin
          state_next_s = ST_FLUSH;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_r == s_index'(num_sets - 1)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_FLUSH;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Requests are only taken while idle and stage B can advance.
  always_comb begin
    req_ready_s = 1'b0;
    case (state_r)
      ST_IDLE:  req_ready_s = !b_valid_r || bus.rsp_ready;
      default:  req_ready_s = 1'b0;
    endcase
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.rsp_valid  = b_valid_r;
  assign bus.rsp_way    = b_valid_r ? way_oh_s : '0;
  assign bus.rsp_miss   = b_valid_r && b_miss_s;
  assign bus.rsp_set    = b_set_r;
  assign bus.flush_busy = flush_busy_r;

  plru_state_ctrl_chk #(.num_ways(num_ways)) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (accept_s),
    .hits   (bus.req_hits)
  );
endmodule

// Protocol checker: an accepted hit vector must be one-hot or all-zero.
module plru_state_ctrl_chk #(
  parameter int num_ways = 4
) (
  input logic                clk,
  input logic                rst_n,
  input logic                accept,
  input logic [num_ways-1:0] hits
);
  a_hits_onehot0: assert property (@(posedge clk) disable iff (!rst_n) accept |-> $onehot0(hits));
endmodule

// File: tb/tb_plru_state_ctrl.sv
// Randomized and directed bench for plru_state_ctrl against a heap-indexed
// tree-PLRU reference model.
module tb_plru_state_ctrl;
  localparam int NB = 3;
  localparam int NS = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  plru_state_ctrl_if #(.s_way(2), .s_index(4)) bus ();
  plru_state_ctrl #(.s_way(2), .s_index(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int m_mem [NS];
  int m_bv, m_bset, m_bhits, m_bupd, m_bbits, m_mode, m_cnt;
  int t1_way [4];
  int t1_state [4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Nodes numbered as a heap: children of n are 2n+1 (lower) and 2n+2.
  function automatic int m_victim(input int bits);
    int n = 0;
    while (n < NB) n = 2 * n + 1 + ((bits >> n) & 1);
    return n - NB;
  endfunction

  function automatic int m_touch(input int bits, input int way);
    int n = way + NB;
    int p;
    while (n > 0) begin
      p = (n - 1) / 2;
      if (n % 2 == 1) bits = bits | (1 << p);
      else            bits = bits & ~(1 << p);
      n = p;
    end
    return bits;
  endfunction

  function automatic int dut_nonzero_sets();
    int cnt = 0;
    for (int i = 0; i < NS; i++) if (dut.plru_mem_r[i] != 3'd0) cnt++;
    return cnt;
  endfunction

  // Reference model: advances on each clock edge from the sampled inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) m_mem[i] <= 0;
      m_bv <= 0; m_bset <= 0; m_bhits <= 0; m_bupd <= 0; m_bbits <= 0;
      m_mode <= 0; m_cnt <= 0;
    end else begin
      int rdy, acc, ret, way, nb, cmt, nmode;
      rdy = (m_mode == 0) && (!m_bv || bus.rsp_ready);
      acc = bus.req_valid && rdy;
      ret = m_bv && bus.rsp_ready;
      way = (m_bhits == 0) ? m_victim(m_bbits) : $clog2(m_bhits);
      nb  = m_touch(m_bbits, way);
      cmt = ret && m_bupd && ($countones(m_bhits) <= 1);
      if (m_mode == 2) m_mem[m_cnt] <= 0;
      else if (cmt)    m_mem[m_bset] <= nb;
      if (acc) begin
        m_bv    <= 1;
        m_bset  <= int'(bus.req_set);
        m_bhits <= int'(bus.req_hits);
        m_bupd  <= int'(bus.req_update);
        m_bbits <= (cmt && m_bset == int'(bus.req_set)) ? nb : m_mem[bus.req_set];
      end else if (ret) begin
        m_bv <= 0;
      end
      nmode = m_mode;
      case (m_mode)
        0: if (bus.flush_req) nmode = (acc || (m_bv && !bus.rsp_ready)) ? 1 : 2;
        1: if (!m_bv || bus.rsp_ready) nmode = 2;
        2: if (m_cnt == NS - 1) nmode = 0;
        default: nmode = 0;
      endcase
      if (m_mode == 2) m_cnt <= (m_cnt + 1) % NS;
      m_mode <= nmode;
    end
  end

  // Compare every output and the whole state array against the model each cycle.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      int ew, bad;
      ew = !m_bv ? 0 : (m_bhits == 0) ? (1 << m_victim(m_bbits)) : m_bhits;
      check("req_ready", int'(bus.req_ready), int'((m_mode == 0) && (!m_bv || bus.rsp_ready)));
      check("rsp_valid", int'(bus.rsp_valid), m_bv);
      check("rsp_way", int'(bus.rsp_way), ew);
      check("rsp_miss", int'(bus.rsp_miss), int'(m_bv != 0 && m_bhits == 0));
      check("rsp_set", int'(bus.rsp_set), m_bset);
      check("flush_busy", int'(bus.flush_busy), int'(m_mode != 0));
      bad = 0;
      for (int i = 0; i < NS; i++) if (int'(dut.plru_mem_r[i]) != m_mem[i]) bad = i;
      check("plru_mem", int'(dut.plru_mem_r[bad]), m_mem[bad]);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    t1_way   = '{1, 4, 2, 8};
    t1_state = '{3, 6, 5, 0};
    bus.req_valid = 1'b0; bus.req_set = 4'd0; bus.req_hits = 4'd0;
    bus.req_update = 1'b0; bus.rsp_ready = 1'b1; bus.flush_req = 1'b0;

    #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", int'(bus.req_ready), 1);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_rsp_way", int'(bus.rsp_way), 0);
    check("rst_rsp_miss", int'(bus.rsp_miss), 0);
    check("rst_rsp_set", int'(bus.rsp_set), 0);
    check("rst_flush_busy", int'(bus.flush_busy), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;

    // Four back-to-back update misses to set 3 cycle through every way.
    bus.req_valid = 1'b1; bus.req_set = 4'd3; bus.req_hits = 4'd0; bus.req_update = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 3) bus.req_valid = 1'b0;
      @(negedge clk);
      check("t1_rsp_way", int'(bus.rsp_way), t1_way[i]);
      check("t1_rsp_miss", int'(bus.rsp_miss), 1);
      if (i > 0) check("t1_state", int'(dut.plru_mem_r[3]), t1_state[i-1]);
    end
    @(posedge clk); #1;
    check("t1_state_final", int'(dut.plru_mem_r[3]), t1_state[3]);

    // Hit on way 2 of set 5.
    bus.req_valid = 1'b1; bus.req_set = 4'd5; bus.req_hits = 4'b0100; bus.req_update = 1'b1;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(negedge clk);
    check("t2_rsp_way", int'(bus.rsp_way), 4);
    check("t2_rsp_miss", int'(bus.rsp_miss), 0);
    @(posedge clk); #1;
    check("t2_state", int'(dut.plru_mem_r[5]), 4);
    check("t2_model_state", m_mem[5], 4);

    // Two peeks to set 7 leave its state untouched.
    bus.req_valid = 1'b1; bus.req_set = 4'd7; bus.req_hits = 4'd0; bus.req_update = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (i == 1) bus.req_valid = 1'b0;
      @(negedge clk);
      check("t3_rsp_way", int'(bus.rsp_way), 1);
    end
    @(posedge clk); #1;
    check("t3_state", int'(dut.plru_mem_r[7]), 0);

    // Stalled response to set 2 commits only on release.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_set = 4'd2; bus.req_hits = 4'd0; bus.req_update = 1'b1;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_req_ready", int'(bus.req_ready), 0);
      check("t4_rsp_way", int'(bus.rsp_way), 1);
      check("t4_rsp_set", int'(bus.rsp_set), 2);
      check("t4_state_held", int'(dut.plru_mem_r[2]), 0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_state_pre", int'(dut.plru_mem_r[2]), 0);
    @(posedge clk); #1;
    check("t4_state_post", int'(dut.plru_mem_r[2]), 3);

    // Bypass: second miss to set 1 is accepted on the first one's commit edge.
    bus.req_valid = 1'b1; bus.req_set = 4'd1; bus.req_hits = 4'd0; bus.req_update = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(negedge clk);
    check("t5_bypass_way", int'(bus.rsp_way), 4);
    @(posedge clk); #1;

    // Flush while stage B is stalled: drain, then a 16-cycle sweep.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_set = 4'd9; bus.req_hits = 4'd0; bus.req_update = 1'b1;
    @(posedge clk); #1; bus.req_valid = 1'b0; bus.flush_req = 1'b1;
    @(posedge clk); #1; bus.flush_req = 1'b0;
    @(negedge clk);
    check("t6_drain_busy", int'(bus.flush_busy), 1);
    check("t6_drain_ready", int'(bus.req_ready), 0);
    @(posedge clk); #1; bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("t6_drain_ready_rel", int'(bus.req_ready), 0);
    @(posedge clk);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.flush_busy) break;
      n++;
    end
    check("t6_flush_cycles", n, 16);
    check("t6_all_clear", dut_nonzero_sets(), 0);
    @(posedge clk); #1;

    // Randomized traffic, biased toward a few sets to exercise the bypass.
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid  = ($urandom_range(0, 3) != 0);
      bus.req_set    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      bus.req_hits   = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'(1 << $urandom_range(0, 3));
      bus.req_update = ($urandom_range(0, 3) != 0);
      bus.rsp_ready  = ($urandom_range(0, 3) != 0);
      bus.flush_req  = ((c % 700) < 30) || ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end

    // Async reset in the middle of a flush sweep.
    bus.req_valid = 1'b0; bus.flush_req = 1'b0; bus.rsp_ready = 1'b1;
    n = 0;
    while (bus.flush_busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid = 1'b1; bus.req_set = 4'd12; bus.req_hits = 4'd0; bus.req_update = 1'b1;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst2_set12_written", int'(dut.plru_mem_r[12] != 3'd0), 1);
    bus.flush_req = 1'b1;
    @(posedge clk); #1; bus.flush_req = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst2_req_ready", int'(bus.req_ready), 1);
    check("rst2_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst2_flush_busy", int'(bus.flush_busy), 0);
    check("rst2_all_clear", dut_nonzero_sets(), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 200; c++) begin
      bus.req_valid  = ($urandom_range(0, 1) != 0);
      bus.req_set    = 4'($urandom_range(0, 3));
      bus.req_hits   = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'(1 << $urandom_range(0, 3));
      bus.req_update = 1'b1;
      bus.rsp_ready  = ($urandom_range(0, 2) != 0);
      bus.flush_req  = 1'b0;
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
